// File: rtl/sram_stream_reader_pkg.sv
// Shared constants and FSM encoding for the SRAM stream reader.
// Sized for the 32x32 register memory.
package sram_stream_reader_pkg;

  localparam int SRAM_ADDR_WIDTH = 5;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_LEN_WIDTH  = 6;
  localparam int SRAM_DEPTH      = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register.
// Accepts a new word whenever it is empty or being drained.
module stream_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         out_ready,
  output logic         load,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;

  always_comb begin
    load    = !valid_q || out_ready;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (flush) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (push && load) begin
      data_d  = in_data;
      valid_d = 1'b1;
      last_d  = in_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Burst read engine: walks memory addresses (wrapping)
// and streams each word over valid/ready.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = SRAM_LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddress,
  input  logic [LEN_WIDTH-1:0]  burstLength,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] dataReadPort,
  output logic [DATA_WIDTH-1:0] streamData,
  output logic                  streamValid,
  input  logic                  streamReady,
  output logic                  streamLast,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN =
    LEN_WIDTH'(2 ** ADDR_WIDTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  len_c;
  logic                  push, flush, load;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    len_c   = (burstLength > MAX_LEN) ? MAX_LEN : burstLength;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (start) begin
          ptr_d = startAddress;
          rem_d = len_c;
          if (len_c == '0) done_d = 1'b1;
          else state_d = ST_READ;
        end
      end
      state_q == ST_READ: begin
        if (abort) begin
          flush   = 1'b1;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else begin
          push = 1'b1;
          if (load) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
          end
        end
      end
      state_q == ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else if (streamValid && streamReady) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  stream_out_reg #(.W(DATA_WIDTH)) u_out (
    .clk       (clock),
    .rst_n     (nReset),
    .push      (push),
    .flush     (flush),
    .in_data   (dataReadPort),
    .in_last   (rem_q == LEN_WIDTH'(1)),
    .out_ready (streamReady),
    .load      (load),
    .out_data  (streamData),
    .out_valid (streamValid),
    .out_last  (streamLast)
  );

  assign readAddress = ptr_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader.
// Expected beats are queued at start and popped on handshakes.
module tb_sram_stream_reader;

  logic        clock;
  logic        nReset;
  logic        start;
  logic [4:0]  startAddress;
  logic [5:0]  burstLength;
  logic        abort;
  logic [4:0]  readAddress;
  logic [31:0] dataReadPort;
  logic [31:0] streamData;
  logic        streamValid;
  logic        streamReady;
  logic        streamLast;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];
  logic [32:0] sb_q [$];
  int          checks;
  int          errors;
  int          beats;
  int          done_cnt;
  int          rdy_mode;
  int          rdy_idx;
  logic        hold_v;
  logic [32:0] hold_w;
  logic        rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  sram_stream_reader dut (
    .clock        (clock),
    .nReset       (nReset),
    .start        (start),
    .startAddress (startAddress),
    .burstLength  (burstLength),
    .abort        (abort),
    .readAddress  (readAddress),
    .dataReadPort (dataReadPort),
    .streamData   (streamData),
    .streamValid  (streamValid),
    .streamReady  (streamReady),
    .streamLast   (streamLast),
    .busy         (busy),
    .done         (done)
  );

  assign dataReadPort = mem[readAddress];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    #2;
    if (rdy_mode == 0) begin
      streamReady = 1'b1;
    end else begin
      streamReady = rdy_pat[rdy_idx % 6];
      rdy_idx++;
    end
  end

  always @(negedge clock) begin
    if (!nReset) begin
      hold_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_v && streamValid)
        chk("stall_hold", {31'd0, streamLast, streamData},
            {31'd0, hold_w});
      hold_v = streamValid && !streamReady;
      hold_w = {streamLast, streamData};
      if (streamValid && streamReady) begin
        beats++;
        if (sb_q.size() == 0)
          chk("sb_underflow", sb_q.size(), 1);
        else
          chk("beat", {31'd0, streamLast, streamData},
              {31'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic start_burst(input logic [4:0] a,
                             input logic [5:0] len,
                             input bit model);
    int n;
    logic [4:0] ad;
    @(posedge clock);
    #2;
    start        = 1'b1;
    startAddress = a;
    burstLength  = len;
    if (model) begin
      n = (len > 32) ? 32 : int'(len);
      for (int i = 0; i < n; i++) begin
        ad = a + 5'(i);
        sb_q.push_back({i == n - 1, mem[ad]});
      end
    end
    @(posedge clock);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b;
    int k;
    b = done_cnt;
    k = 0;
    while (done_cnt == b && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("done_seen", done_cnt - b, 1);
  endtask

  initial begin
    int b;
    int dc;
    checks   = 0;
    errors   = 0;
    beats    = 0;
    done_cnt = 0;
    rdy_mode = 0;
    rdy_idx  = 0;
    hold_v   = 1'b0;
    hold_w   = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    nReset       = 1'b0;
    start        = 1'b0;
    startAddress = '0;
    burstLength  = '0;
    abort        = 1'b0;
    streamReady  = 1'b1;
    #7;
    chk("rst_addr", readAddress, 0);
    chk("rst_valid", streamValid, 0);
    chk("rst_last", streamLast, 0);
    chk("rst_data", streamData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clock);
    #2;
    nReset = 1'b1;

    start_burst(5'd3, 6'd4, 1);
    @(negedge clock);
    #1;
    chk("lat_addr", readAddress, 3);
    chk("lat_busy", busy, 1);
    chk("lat_valid", streamValid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk("consec_valid", streamValid, 1);
    end
    @(negedge clock);
    #1;
    chk("done_pulse", done, 1);
    chk("done_valid", streamValid, 0);
    chk("done_busy", busy, 0);
    @(negedge clock);
    #1;
    chk("done_width", done, 0);
    chk("basic_sb", sb_q.size(), 0);

    start_burst(5'd3, 6'd4, 1);
    @(posedge clock);
    #2;
    @(posedge clock);
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_addr", readAddress, 0);
    chk("arst_valid", streamValid, 0);
    chk("arst_last", streamLast, 0);
    chk("arst_data", streamData, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_left", sb_q.size(), 3);
    sb_q.delete();
    @(posedge clock);
    #2;
    nReset = 1'b1;
    start_burst(5'd10, 6'd3, 1);
    wait_done(50);
    chk("post_rst_sb", sb_q.size(), 0);

    start_burst(5'd30, 6'd4, 1);
    wait_done(50);
    chk("wrap_sb", sb_q.size(), 0);

    b = beats;
    start_burst(5'd0, 6'd40, 1);
    wait_done(100);
    chk("clamp_beats", beats - b, 32);
    chk("clamp_sb", sb_q.size(), 0);

    rdy_mode = 1;
    b = beats;
    start_burst(5'd8, 6'd8, 1);
    wait_done(100);
    rdy_mode = 0;
    chk("bp_beats", beats - b, 8);
    chk("bp_sb", sb_q.size(), 0);

    b = beats;
    start_burst(5'd7, 6'd0, 1);
    @(negedge clock);
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", streamValid, 0);
    @(negedge clock);
    #1;
    chk("zero_done_end", done, 0);
    chk("zero_beats", beats - b, 0);

    start_burst(5'd12, 6'd6, 1);
    repeat (2) @(posedge clock);
    #2;
    start        = 1'b1;
    startAddress = 5'd9;
    burstLength  = 6'd3;
    @(posedge clock);
    #2;
    start = 1'b0;
    wait_done(100);
    chk("busy_start_sb", sb_q.size(), 0);
    dc = done_cnt;
    repeat (5) @(negedge clock);
    #1;
    chk("busy_start_idle", busy, 0);
    chk("busy_start_nodone", done_cnt - dc, 0);

    b = beats;
    start_burst(5'd20, 6'd6, 1);
    @(posedge clock);
    #2;
    @(posedge clock);
    #2;
    abort = 1'b1;
    dc = done_cnt;
    @(posedge clock);
    #2;
    abort = 1'b0;
    @(negedge clock);
    #1;
    chk("abort_valid", streamValid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_beats", beats - b, 2);
    chk("abort_left", sb_q.size(), 4);
    sb_q.delete();
    repeat (4) @(negedge clock);
    #1;
    chk("abort_nodone", done_cnt - dc, 0);
    start_burst(5'd5, 6'd2, 1);
    wait_done(50);
    chk("abort_next_sb", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
